parity_arbiter: RTL and testbench
=================================

# parity_arbiter

Round-robin arbiter and sequencer that shares a single parity-generation datapath among `NUM_REQ` requesters. Each requester presents a `DATA_W`-bit word with a valid/ready handshake. The winner's word is registered together with its parity bit and requester ID into a one-entry output stage, and drained through a valid/ready port. The block sits between multiple data sources and a downstream framer/checker that consumes parity-tagged words.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_W`, 4: data word width; legal value ≥1.
- `PARITY_ODD`, 0: 0 selects even parity (`parity` = XOR of all data bits); 1 selects odd parity (`parity` = inverted XOR).
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NUM_REQ`: bit i is high when requester i has a word.
- `req_data` in `NUM_REQ*DATA_W`: requester i's word is in bits `[i*DATA_W +: DATA_W]`.
- `req_ready` out `NUM_REQ`: one-hot or zero grant; combinational.
- `out_valid` out 1: the output stage holds a word.
- `out_data` out `DATA_W`: the registered winner word.
- `out_parity` out 1: parity of `out_data` per `PARITY_ODD`.
- `out_id` out `ID_W`: index of the requester that supplied `out_data`.
- `out_ready` in 1: the downstream accepts the word this cycle.
- `xfer_count` out 16: count of completed output transfers; wraps modulo 2^16.

## Operation
- Output stage is a 2-state FSM:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- Define `accept` = EMPTY, or (FULL and `out_ready`). This allows same-cycle drain and refill.
- Arbitration:
  - Search starts at the pointer `rr_ptr` and proceeds `rr_ptr`, `rr_ptr`+1, …, wrapping modulo `NUM_REQ`.
  - The first i with `req_valid[i]`=1 is the winner.
  - `req_ready[winner]` = `accept`; all other `req_ready` bits are 0.
  - If no `req_valid` bit is set, `req_ready` is all 0.
- Input transfer occurs when `req_valid[i]` and `req_ready[i]` are both high. On that edge:
  - `out_data` ← winner word; `out_parity` ← computed parity; `out_id` ← i.
  - State goes to FULL.
  - `rr_ptr` ← (i+1) mod `NUM_REQ`.
- Output drain: on FULL with `out_ready` and no new input transfer, state goes to EMPTY. `out_data`, `out_id` and `out_parity` are don't-care but hold their last values.
- `rr_ptr` changes only on an input transfer. An idle cycle does not move it.
- `xfer_count` increments on every cycle where `out_valid` and `out_ready` are both high. It rolls from 16'hFFFF to 16'h0000.
- FULL with `out_ready`=0: `out_*` is held bit-stable and `req_ready` is all 0 (backpressure).
- Requesters must not make `req_valid` depend on `req_ready`. `req_ready` depends combinationally on `req_valid`, `rr_ptr`, `out_valid` and `out_ready`.
- A requester that drops `req_valid` without a transfer is simply skipped. There is no internal queueing.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets: state EMPTY, `out_valid`=0, `out_data`=0, `out_parity`=`PARITY_ODD`, `out_id`=0, `rr_ptr`=0, `xfer_count`=0.
- `req_ready` is 0 while `rst_n`=0.
- Reset mid-operation discards any held word without counting it; no transfer completes on the reset edge.
- Latency: a word accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: one word per cycle while `out_ready`=1 and at least one requester is valid.
- Simultaneous drain and refill in the same cycle: `out_valid` stays 1, and the new word replaces the old one at the edge.
- Fairness: with all requesters continuously valid, each is granted exactly once in every `NUM_REQ` consecutive transfers.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with all `req_valid`=1 -> `req_ready`=0, `out_valid`=0, `xfer_count`=0, `out_parity`=0 (even build).
- **Single requester:** requester 2 presents 4'b1011 with `out_ready`=1 -> `req_ready`=4'b0100 for one cycle; next cycle `out_data`=4'b1011, `out_parity`=1, `out_id`=2; `xfer_count` reaches 1.
- **Round-robin:** `req_valid`=4'b1111 continuously with `out_ready`=1 -> grant sequence 0,1,2,3,0,1; one word per cycle; `xfer_count` increments every cycle.
- **Backpressure:** FULL with `out_ready`=0 for 5 cycles -> `out_*` stable, `req_ready`=0, `xfer_count` unchanged. Release `out_ready` -> a drain and refill happen in the same cycle.
- **Odd parity build:** `PARITY_ODD`=1 with data 4'b0000 -> `out_parity`=1; with data 4'b0111 -> `out_parity`=0.
- **Reset mid-operation and counter wrap:**
  - Assert `rst_n`=0 while FULL -> `out_valid`=0 and `rr_ptr`=0 after the edge; the next grant with 4'b1111 valid goes to requester 0.
  - Preload `xfer_count` to 16'hFFFF via 65535 transfers, then one more transfer -> `xfer_count`=0.

Source files
------------

// File: rtl/parity_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : parity_arbiter
// Description : Round-robin arbiter that shares one parity datapath among
//               NUM_REQ requesters. The winning word is stored with its parity
//               and requester ID in a one-entry valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 4,
    parameter int PARITY_ODD = 0,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_parity,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic [15:0]               xfer_count
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ID_W:0]   c_num_req    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last_id    = ID_W'(NUM_REQ-1);
    localparam logic            c_parity_odd = (PARITY_ODD != 0);

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_parity;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [15:0]       r_xfer_count;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W:0]     w_idx;
    logic [DATA_W-1:0] w_word;
    logic              w_parity;
    logic              w_accept;
    logic              w_grant;
    logic              w_out_xfer;
    logic [ID_W-1:0]   w_next_ptr;

    // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the extra index bit keeps
    // the unwrapped sum (at most 2*NUM_REQ-2) from overflowing.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_parity   = (^w_word) ^ c_parity_odd;
    assign w_accept   = (r_state == ST_EMPTY) || out_ready;
    assign w_grant    = rst_n && w_found && w_accept;
    assign w_out_xfer = (r_state == ST_FULL) && out_ready;
    assign w_next_ptr = (w_winner == c_last_id) ? '0 : w_winner + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant && (w_winner == ID_W'(i));
        end
    end

    // A grant always loads the stage, even when the old word drains on the
    // same edge, so FULL is kept and the new word overwrites the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_data       <= '0;
            r_parity     <= c_parity_odd;
            r_id         <= '0;
            r_rr_ptr     <= '0;
            r_xfer_count <= '0;
        end else begin
            if (w_grant) begin
                r_state  <= ST_FULL;
                r_data   <= w_word;
                r_parity <= w_parity;
                r_id     <= w_winner;
                r_rr_ptr <= w_next_ptr;
            end else if (w_out_xfer) begin
                r_state  <= ST_EMPTY;
            end
            if (w_out_xfer) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    assign out_valid  = (r_state == ST_FULL);
    assign out_data   = r_data;
    assign out_parity = r_parity;
    assign out_id     = r_id;
    assign xfer_count = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_parity_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_arbiter
// Description : Scoreboard bench for parity_arbiter (even and odd builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 2;
    localparam int SB_W    = DATA_W + 1 + ID_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_parity;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;
    logic [15:0]               xfer_count;

    logic [NUM_REQ-1:0]        odd_req_valid;
    logic [NUM_REQ*DATA_W-1:0] odd_req_data;
    logic [NUM_REQ-1:0]        odd_req_ready;
    logic                      odd_out_valid;
    logic [DATA_W-1:0]         odd_out_data;
    logic                      odd_out_parity;
    logic [ID_W-1:0]           odd_out_id;
    logic                      odd_out_ready;
    logic [15:0]               odd_xfer_count;

    parity_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PARITY_ODD(0), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    parity_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PARITY_ODD(1), .ID_W(ID_W)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (odd_req_valid),
        .req_data   (odd_req_data),
        .req_ready  (odd_req_ready),
        .out_valid  (odd_out_valid),
        .out_data   (odd_out_data),
        .out_parity (odd_out_parity),
        .out_id     (odd_out_id),
        .out_ready  (odd_out_ready),
        .xfer_count (odd_xfer_count)
    );

    logic [SB_W-1:0] sb[$];
    logic [SB_W-1:0] mon_exp;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SB_W-1:0] ent(input logic [3:0] d, input logic p, input logic [1:0] id);
        return {d, p, id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer is matched against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got word %h with no expected entry", {out_data, out_parity, out_id});
            end else begin
                mon_exp = sb.pop_front();
                chk("out_word", 16'({out_data, out_parity, out_id}), 16'(mon_exp));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] rr_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] rr_ids [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] rr_dat [6] = '{4'h1, 4'h6, 4'hB, 4'hE, 4'h1, 4'h6};
    logic       rr_par [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n         = 1'b0;
        req_valid     = 4'hF;
        req_data      = {4'hE, 4'hB, 4'h6, 4'h1};
        out_ready     = 1'b0;
        odd_req_valid = 4'hF;
        odd_req_data  = '0;
        odd_out_ready = 1'b1;

        // Reset held for three edges with all requesters valid
        repeat (3) step();
        @(negedge clk);
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_xfer_count", xfer_count, 16'h0);
        chk("rst_parity_even", 16'(out_parity), 16'h0);
        chk("rst_parity_odd", 16'(odd_out_parity), 16'h1);
        step();
        rst_n         = 1'b1;
        req_valid     = 4'h0;
        out_ready     = 1'b1;
        odd_req_valid = 4'b0001;

        // Odd build: 0000 -> 1, then 0111 -> 0
        @(negedge clk);
        chk("odd_req_ready", 16'(odd_req_ready), 16'h1);
        step();
        odd_req_data = {12'h000, 4'b0111};
        @(negedge clk);
        chk("odd_parity_0000", 16'({odd_out_data, odd_out_parity}), 16'({4'b0000, 1'b1}));
        step();
        odd_req_valid = 4'h0;
        @(negedge clk);
        chk("odd_parity_0111", 16'({odd_out_data, odd_out_parity}), 16'({4'b0111, 1'b0}));
        step();

        // Single requester 2 presenting 1011
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_req_ready", 16'(req_ready), 16'h4);
        sb.push_back(ent(4'hB, 1'b1, 2'd2));
        step();
        req_valid = 4'h0;
        @(negedge clk);
        chk("single_out_valid", 16'(out_valid), 16'h1);
        chk("single_ready_idle", 16'(req_ready), 16'h0);
        step();
        @(negedge clk);
        chk("single_xfer_count", xfer_count, 16'h1);
        chk("single_drained", 16'(out_valid), 16'h0);

        // Pointer back to 0, then all requesters valid continuously
        step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_grant", 16'(req_ready), 16'(rr_tab[k]));
            chk("rr_xfer_count", xfer_count, (k == 0) ? 16'd0 : 16'(k - 1));
            sb.push_back(ent(rr_dat[k], rr_par[k], rr_ids[k]));
            step();
        end
        req_valid = 4'h0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("rr_final_count", xfer_count, 16'd6);
        chk("rr_drained", 16'(out_valid), 16'h0);

        // Backpressure: fill while EMPTY, then hold for five cycles
        step();
        out_ready = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("bp_fill_grant", 16'(req_ready), 16'h4);
        sb.push_back(ent(4'hB, 1'b1, 2'd2));
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_req_ready", 16'(req_ready), 16'h0);
            chk("bp_hold", 16'({out_valid, out_data, out_parity, out_id}), 16'({1'b1, 4'hB, 1'b1, 2'd2}));
            chk("bp_xfer_count", xfer_count, 16'd6);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_refill_grant", 16'(req_ready), 16'h8);
        sb.push_back(ent(4'hE, 1'b1, 2'd3));
        step();
        req_valid = 4'h0;
        @(negedge clk);
        chk("bp_refill_valid", 16'({out_valid, out_id}), 16'({1'b1, 2'd3}));
        chk("bp_count_after", xfer_count, 16'd7);
        step();
        @(negedge clk);
        chk("bp_final_count", xfer_count, 16'd8);

        // Reset while FULL discards the word and rewinds the pointer
        step();
        out_ready = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("mid_grant", 16'(req_ready), 16'h2);
        step();
        req_valid = 4'h0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("mid_full", 16'(out_valid), 16'h1);
        step();
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_count", xfer_count, 16'h0);
        chk("mid_rst_ready", 16'(req_ready), 16'h0);
        step();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_after_grant", 16'(req_ready), 16'h1);
        sb.push_back(ent(4'h1, 1'b1, 2'd0));
        step();

        // 65536 back-to-back words from requester 0 to wrap the counter
        req_valid = 4'b0001;
        for (int n = 1; n < 65536; n++) begin
            @(negedge clk);
            sb.push_back(ent(4'h1, 1'b1, 2'd0));
            step();
        end
        req_valid = 4'h0;
        @(negedge clk);
        chk("wrap_ffff", xfer_count, 16'hFFFF);
        step();
        @(negedge clk);
        chk("wrap_zero", xfer_count, 16'h0000);
        chk("wrap_drained", 16'(out_valid), 16'h0);
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
